// File: rtl/spi_master.sv
// ============================================================================
// Module  : spi_master
// Brief   : Mode-0 SPI master (MSB first, 8-bit frames) with a valid/ready
//           byte stream. Optional loopback port when SPI_MASTER_LOOPBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       MISO
);

  if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_clk_div_range
    $error("spi_master: CLK_DIV=%0d outside legal range 4..255", CLK_DIV);
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_WAIT = 3'd3,
    S_HOLD = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shreg;      // bits still to send; the current bit sits in MOSI
  logic [7:0]  rxsh;
  logic        last_r;
  logic        miso_meta, miso_sync;
  logic        rx_bit;
  logic        phase_end, timed;
  logic        load, sample, shift, finish;
  logic        sck_n, ssel_n;

  assign phase_end = (div_cnt == DIV_LAST);
  assign timed     = (state == S_LOW) || (state == S_HIGH) ||
                     (state == S_HOLD) || (state == S_GAP);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback ? MOSI : miso_sync;
`else
  assign rx_bit = miso_sync;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_ready = 1'b0;
    load     = 1'b0;
    sample   = 1'b0;
    shift    = 1'b0;
    finish   = 1'b0;
    sck_n    = SCK;
    ssel_n   = SSEL;
    case (state)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load    = 1'b1;
          ssel_n  = 1'b0;
          state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          sck_n   = 1'b1;
          sample  = 1'b1;
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          sck_n = 1'b0;
          if (bit_cnt == 3'd7) begin
            finish  = 1'b1;
            state_n = last_r ? S_HOLD : S_WAIT;
          end else begin
            shift   = 1'b1;
            state_n = S_LOW;
          end
        end
      end
      S_WAIT: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          load    = 1'b1;
          state_n = S_LOW;
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          ssel_n  = 1'b1;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_end) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      div_cnt   <= 8'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      rxsh      <= 8'd0;
      last_r    <= 1'b0;
      SCK       <= 1'b0;
      SSEL      <= 1'b1;
      MOSI      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'd0;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
      div_cnt   <= (timed && !phase_end) ? div_cnt + 8'd1 : 8'd0;
      SCK       <= sck_n;
      SSEL      <= ssel_n;
      rx_valid  <= finish;
      if (load) begin
        MOSI    <= tx_data[7];
        shreg   <= tx_data[6:0];
        last_r  <= tx_last;
        bit_cnt <= 3'd0;
      end
      if (sample) rxsh <= {rxsh[6:0], rx_bit};
      if (shift) begin
        MOSI    <= shreg[6];
        shreg   <= {shreg[5:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (finish) rx_data <= rxsh;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module  : tb_spi_master
// Brief   : Randomised self-checking bench for spi_master with a behavioural
//           mode-0 slave and a timing/data reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  localparam int CLK_DIV = 8;
  localparam int LIMIT   = 2000;

  logic       clk, rst_n;
  logic       tx_valid, tx_ready, tx_last;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       SCK, SSEL, MOSI, MISO;
  logic       s_miso;
  logic       loop_mode;

  int n_checks = 0;
  int n_pass   = 0;

  assign MISO = loop_mode ? 1'b0 : s_miso;

  spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .SCK      (SCK),
    .SSEL     (SSEL),
    .MOSI     (MOSI),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback (loop_mode),
`endif
    .MISO     (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state: expected bytes and load times, all sampled at negedge
  logic [7:0] sent_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] slave_q[$];
  int         load_q[$];
  int  ncyc = 0, rises = 0, rx_cnt = 0, windows = 0;
  int  low_len = 0, high_len = 0, pulses = 0;
  int  win_first = 0, win_last = 0, win_nb = 0;
  int  last_low_len = 0, last_pulses = 0, last_gap = 0;
  bit  in_win = 0, have_gap = 0;
  logic p_sck = 1'b0, p_ssel = 1'b1, p_rxv = 1'b0;
  int   s_cnt = 0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00, tmp;

  function automatic logic [7:0] next_slave_byte();
    if (slave_q.size() > 0) return slave_q.pop_front();
    return 8'($urandom);
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      sent_q.delete(); exp_rx.delete(); load_q.delete();
      in_win = 0; have_gap = 0; win_nb = 0; s_cnt = 0;
    end else begin
      if (tx_valid && tx_ready) begin
        sent_q.push_back(tx_data);
        load_q.push_back(ncyc + 1);
        if (win_nb == 0) win_first = ncyc + 1;
        win_last = ncyc + 1;
        win_nb++;
      end
      if (SCK && !p_sck) begin
        rises++;
        if (in_win) pulses++;
      end
      if (!SSEL) begin
        if (p_ssel) begin
          if (have_gap) begin
            check("ssel_gap_min", 32'(high_len >= CLK_DIV), 1);
            last_gap = high_len;
          end
          in_win = 1; low_len = 0; pulses = 0;
        end
        low_len++;
      end else begin
        if (!p_ssel && in_win) begin
          check("ssel_low_len", low_len, win_last - win_first + 17 * CLK_DIV);
          check("sck_pulses", pulses, 8 * win_nb);
          check("gap_tx_ready", 32'(tx_ready), 0);
          last_low_len = low_len; last_pulses = pulses;
          windows++; win_nb = 0; in_win = 0; have_gap = 1; high_len = 0;
        end
        high_len++;
      end
      // Behavioural mode-0 slave
      if (p_ssel && !SSEL) begin
        s_cnt = 0; s_tx = next_slave_byte(); s_miso = s_tx[7];
      end else if (!SSEL && SCK && !p_sck) begin
        s_rx = {s_rx[6:0], MOSI};
        s_cnt++;
        if (s_cnt == 8) begin
          if (sent_q.size() == 0) check("mosi_unexpected", 1, 0);
          else begin
            tmp = sent_q.pop_front();
            check("mosi_byte", 32'(s_rx), 32'(tmp));
            exp_rx.push_back(loop_mode ? tmp : s_tx);
          end
        end
      end else if (!SSEL && !SCK && p_sck) begin
        if (s_cnt == 8) begin
          s_cnt = 0; s_tx = next_slave_byte();
        end
        s_miso = s_tx[3'(7 - s_cnt)];
      end
      if (rx_valid) begin
        rx_cnt++;
        if (p_rxv) check("rx_valid_pulse", 1, 0);
        if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
        else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        if (load_q.size() > 0) check("rx_latency", ncyc - load_q.pop_front(), 16 * CLK_DIV);
      end
    end
    p_sck = SCK; p_ssel = SSEL; p_rxv = rx_valid;
  end

  // Driver tasks start and end at #1 after a rising edge
  task automatic send_byte(input logic [7:0] d, input logic l);
    int w = 0;
    tx_valid = 1'b1;
    while (!tx_ready && w < LIMIT) begin
      tx_data = 8'($urandom); tx_last = 1'($urandom);
      @(posedge clk); #1; w++;
    end
    check("tx_accept", 32'(w < LIMIT), 1);
    tx_data = d; tx_last = l;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'($urandom); tx_last = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(SSEL && tx_ready && !in_win) && w < LIMIT) begin idle_cycles(1); w++; end
    check("idle_reached", 32'(w < LIMIT), 1);
  endtask

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, bad, nb;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    loop_mode = 1'b0; s_miso = 1'b0;
    idle_cycles(3);
    check("rst_sck", 32'(SCK), 0);
    check("rst_ssel", 32'(SSEL), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    rst_n = 1'b1;
    idle_cycles(1);
    check("rst_tx_ready", 32'(tx_ready), 1);

    // Single byte 0xA5, slave answers 0x3C
    slave_q.push_back(8'h3C);
    send_byte(8'hA5, 1'b1);
    wait_idle();
    check("a5_rx_data", 32'(rx_data), 32'h3C);
    check("a5_low_len", last_low_len, 17 * CLK_DIV);
    check("a5_pulses", last_pulses, 8);

    // Three bytes in one transaction
    w0 = windows; r0 = rx_cnt;
    slave_q.push_back(8'h9A); slave_q.push_back(8'h5B); slave_q.push_back(8'hE7);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    wait_idle();
    check("multi_windows", windows - w0, 1);
    check("multi_pulses", last_pulses, 24);
    check("multi_rx_count", rx_cnt - r0, 3);
    check("multi_last_rx", 32'(rx_data), 32'hE7);

    // Stalled stream: WAIT must keep SCK low, SSEL low, tx_ready high
    r0 = rx_cnt;
    send_byte(8'h55, 1'b0);
    bad = 0;
    while (rx_cnt == r0 && bad < LIMIT) begin idle_cycles(1); bad++; end
    check("stall_rx_seen", 32'(bad < LIMIT), 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (SCK || SSEL || !tx_ready) bad++;
      idle_cycles(1);
    end
    check("stall_wait_state", bad, 0);
    send_byte(8'hAA, 1'b1);
    wait_idle();
    check("stall_pulses", last_pulses, 16);

    // Back-to-back single-byte transactions
    send_byte(8'h3E, 1'b1);
    send_byte(8'hC1, 1'b1);
    wait_idle();
    check("b2b_gap", last_gap, CLK_DIV + 1);

    // Reset in HIGH of bit 3
    r0 = rises;
    send_byte(8'hFF, 1'b1);
    bad = 0;
    while (rises < r0 + 4 && bad < LIMIT) begin idle_cycles(1); bad++; end
    check("rst_mid_reach", 32'(bad < LIMIT), 1);
    idle_cycles(1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sck", 32'(SCK), 0);
    check("rst_mid_ssel", 32'(SSEL), 1);
    check("rst_mid_mosi", 32'(MOSI), 0);
    check("rst_mid_rx_valid", 32'(rx_valid), 0);
    check("rst_mid_rx_data", 32'(rx_data), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_mid_tx_ready", 32'(tx_ready), 1);
    idle_cycles(2);

    // Randomised transactions
    for (int t = 0; t < 20; t++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 30));
        send_byte(8'($urandom), b == nb - 1);
      end
      idle_cycles($urandom_range(0, 12));
    end
    wait_idle();

`ifdef SPI_MASTER_LOOPBACK_EN
    loop_mode = 1'b1;
    send_byte(8'hC3, 1'b1);
    wait_idle();
    check("loopback_rx", 32'(rx_data), 32'hC3);
    loop_mode = 1'b0;
`endif

    idle_cycles(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
